adc_spi_slave: RTL and testbench

//  SPI responder for the 16-bit ADC read link: emulates the converter side in FPGA fabric.

---
 rtl/adc_spi_pkg.sv | 14 +
 rtl/spi_in_sync.sv | 27 ++
 rtl/adc_spi_slave.sv | 146 ++++++++++++++
 tb/tb_adc_spi_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared constants and state encoding for the ADC SPI responder.
package adc_spi_pkg;

    localparam int ADC_DATA_W      = 16;
    localparam int ADC_SYNC_STAGES = 2;
    localparam logic [ADC_DATA_W-1:0] ADC_IDLE_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } adc_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Pin synchroniser with edge detection for one asynchronous SPI input.
// The chain is deliberately not reset: a reset while cs is held low must not
// fabricate a cs fall and restart a frame part-way through.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Metastability chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], pin};
        hist_q <= sync_q[STAGES-1];
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~hist_q;
    assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/adc_spi_slave.sv
// SPI mode-0 responder emulating the ADC side of the read link.
// Handshake: din is accepted on a clock where din_valid && din_ready are both 1;
// din_valid may be held, and din must be stable while din_valid is high and
// din_ready is low.
module adc_spi_slave import adc_spi_pkg::*; #(
    parameter int                DATA_W      = ADC_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(ADC_IDLE_WORD),
    parameter int                SYNC_STAGES = ADC_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] cfg_word,
    output logic              cfg_valid,
    output logic              frame_err,
    output logic              busy,
    output adc_state_t        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    adc_state_t        state, state_nxt;
    logic              cs_lvl, cs_rise, cs_fall;
    logic              sclk_lvl_unused, sclk_rise, sclk_fall;
    logic              mosi_lvl, mosi_rise_unused, mosi_fall_unused;
    logic              full;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, load_word;
    logic [CNT_W-1:0]  bit_cnt;
    logic              load, sclk_rise_v, sclk_fall_v, last_rise;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .pin(cs), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .pin(sclk), .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .pin(mosi), .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // sclk edges only count while cs is low; a cs rise always wins over them.
    assign sclk_rise_v = sclk_rise & ~cs_lvl & ~cs_rise;
    assign sclk_fall_v = sclk_fall & ~cs_lvl & ~cs_rise;
    assign last_rise   = sclk_rise_v && (bit_cnt == CNT_W'(DATA_W - 1));
    assign load        = (state == ST_IDLE) && cs_fall;
    assign load_word   = full ? hold : IDLE_WORD;
    assign rx_next     = {rx_sr[DATA_W-2:0], mosi_lvl};
    assign din_ready   = ~full;
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: IDLE -> SHIFT on cs fall, SHIFT -> DONE on the last rise.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise)        state_nxt = ST_IDLE;
                else if (last_rise) state_nxt = ST_DONE;
            end
            ST_DONE:  if (cs_rise) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // One-entry holding register; a same-cycle load reads the old (empty) content.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            hold <= '0;
        end else if (din_valid && !full) begin
            full <= 1'b1;
            hold <= din;
        end else if (load) begin
            full <= 1'b0;
        end
    end

    // Shift registers, bit counter and registered pin/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            cfg_word  <= '0;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        tx_sr   <= load_word;
                        miso    <= load_word[DATA_W-1];
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                    end else if (sclk_rise_v) begin
                        rx_sr   <= rx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_rise) begin
                            cfg_word  <= rx_next;
                            cfg_valid <= 1'b1;
                            miso      <= 1'b0;
                        end
                    end else if (sclk_fall_v) begin
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        miso  <= tx_sr[DATA_W-2];
                    end
                end
                ST_DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) miso_oe <= 1'b0;
                end
                default: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_slave.sv
// Bench for adc_spi_slave: a mode-0 master at clk/10 plus a queue model of the
// sample path (accepted words served in order, IDLE_WORD when nothing queued).
module tb_adc_spi_slave;
    import adc_spi_pkg::*;

    localparam int W = 16;
    localparam logic [W-1:0] IDLE_W = 16'h0000;

    logic         clk, rst, cs, sclk, mosi, miso, miso_oe;
    logic [W-1:0] din, cfg_word;
    logic         din_valid, din_ready, cfg_valid, frame_err, busy;
    adc_state_t   dbg_state;

    adc_spi_slave dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .frame_err(frame_err), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int cfg_pulses = 0;
    int err_pulses = 0;
    logic feed_stop;

    // Pulse counters for the single-cycle status outputs.
    always @(negedge clk) begin
        if (cfg_valid === 1'b1) cfg_pulses++;
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_next();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return IDLE_W;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " miso"},      {31'd0, miso},      32'd0);
        check({tag, " miso_oe"},   {31'd0, miso_oe},   32'd0);
        check({tag, " din_ready"}, {31'd0, din_ready}, 32'd1);
        check({tag, " cfg_word"},  {16'd0, cfg_word},  32'd0);
        check({tag, " cfg_valid"}, {31'd0, cfg_valid}, 32'd0);
        check({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, " busy"},      {31'd0, busy},      32'd0);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (din_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push timeout", 32'd0, 32'd1);
        din = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        exp_q.push_back(w);
    endtask

    // Mode-0 master: mosi changes with sclk low, miso sampled just before each rise.
    task automatic spi_frame(input logic [W-1:0] mo, input int nbits, input int rst_bit,
                             output logic [31:0] rx, output int extra_ones, output logic oe_start);
        logic b;
        rx = '0;
        extra_ones = 0;
        oe_start = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < W) ? mo[W-1-i] : 1'b0;
            wait_clk(5);
            b = miso;
            if (i == 0) oe_start = miso_oe;
            if (i < W) rx = {rx[30:0], b};
            else if (b !== 1'b0) extra_ones++;
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_reset_vals("mid reset");
            end
        end
        wait_clk(5);
        cs = 1'b1;
        wait_clk(8);
    endtask

    logic [31:0] rx;
    int          extra;
    logic        oe0;
    logic [W-1:0] e, mo, last_cfg;
    int          c0, e0;

    initial begin
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0; din = '0; din_valid = 1'b0; rst = 1'b1;
        feed_stop = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check_reset_vals("reset");

        // Queued sample out, command in.
        push_word(16'hBFFF);
        c0 = cfg_pulses;
        spi_frame(16'hA5C3, 16, -1, rx, extra, oe0);
        e = model_next();
        check("t1 miso word", rx, {16'd0, e});
        check("t1 cfg_word", {16'd0, cfg_word}, 32'h0000A5C3);
        check("t1 cfg pulses", cfg_pulses - c0, 32'd1);
        check("t1 oe in frame", {31'd0, oe0}, 32'd1);
        check("t1 oe after", {31'd0, miso_oe}, 32'd0);
        check("t1 busy after", {31'd0, busy}, 32'd0);

        // Nothing queued: IDLE_WORD goes out.
        mo = 16'($urandom);
        spi_frame(mo, 16, -1, rx, extra, oe0);
        e = model_next();
        check("t2 miso idle", rx, {16'd0, e});
        check("t2 din_ready", {31'd0, din_ready}, 32'd1);
        check("t2 cfg_word", {16'd0, cfg_word}, {16'd0, mo});

        // Streaming source across three frames.
        c0 = cfg_pulses;
        fork
            begin
                @(posedge clk); #1;
                din = 16'($urandom);
                din_valid = 1'b1;
                while (!feed_stop) begin
                    logic pend;
                    pend = din_ready;
                    @(posedge clk); #1;
                    if (pend) begin
                        exp_q.push_back(din);
                        din = 16'($urandom);
                    end
                end
                din_valid = 1'b0;
            end
            begin
                wait_clk(10);
                for (int f = 0; f < 3; f++) begin
                    mo = 16'($urandom);
                    spi_frame(mo, 16, -1, rx, extra, oe0);
                    e = model_next();
                    check("t3 miso word", rx, {16'd0, e});
                    check("t3 cfg_word", {16'd0, cfg_word}, {16'd0, mo});
                    wait_clk(42);
                end
                feed_stop = 1'b1;
            end
        join
        wait_clk(3);
        check("t3 cfg pulses", cfg_pulses - c0, 32'd3);
        check("t3 din_ready", {31'd0, din_ready}, {31'd0, exp_q.size() == 0});
        last_cfg = mo;

        // Short frame: error pulse, command untouched, sample consumed.
        e0 = err_pulses;
        c0 = cfg_pulses;
        spi_frame(16'($urandom), 7, -1, rx, extra, oe0);
        e = model_next();
        check("t4 partial bits", rx, {25'd0, e[15:9]});
        check("t4 err pulses", err_pulses - e0, 32'd1);
        check("t4 cfg pulses", cfg_pulses - c0, 32'd0);
        check("t4 cfg_word kept", {16'd0, cfg_word}, {16'd0, last_cfg});
        check("t4 oe", {31'd0, miso_oe}, 32'd0);
        check("t4 din_ready", {31'd0, din_ready}, 32'd1);
        mo = 16'($urandom);
        spi_frame(mo, 16, -1, rx, extra, oe0);
        e = model_next();
        check("t4 next miso", rx, {16'd0, e});
        check("t4 next cfg", {16'd0, cfg_word}, {16'd0, mo});

        // Reset part-way through a frame.
        push_word(16'($urandom));
        e0 = err_pulses;
        c0 = cfg_pulses;
        spi_frame(16'($urandom), 16, 9, rx, extra, oe0);
        e = model_next();
        exp_q.delete();
        check("t5 bits before rst", rx[15:6], {22'd0, e[15:6]});
        check("t5 bits after rst", rx[5:0], 32'd0);
        check("t5 no cfg pulse", cfg_pulses - c0, 32'd0);
        check("t5 no err pulse", err_pulses - e0, 32'd0);
        check("t5 cfg_word", {16'd0, cfg_word}, 32'd0);
        push_word(16'($urandom));
        mo = 16'($urandom);
        spi_frame(mo, 16, -1, rx, extra, oe0);
        e = model_next();
        check("t5 clean miso", rx, {16'd0, e});
        check("t5 clean cfg", {16'd0, cfg_word}, {16'd0, mo});

        // Overlong frame: first 16 bits count, miso low afterwards.
        e0 = err_pulses;
        c0 = cfg_pulses;
        push_word(16'($urandom));
        spi_frame(16'h1234, 20, -1, rx, extra, oe0);
        e = model_next();
        check("t6 cfg_word", {16'd0, cfg_word}, 32'h00001234);
        check("t6 extra miso", extra, 32'd0);
        check("t6 miso word", rx, {16'd0, e});
        check("t6 cfg pulses", cfg_pulses - c0, 32'd1);
        check("t6 err pulses", err_pulses - e0, 32'd0);

        // Random mix of queued and empty frames.
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) push_word(16'($urandom));
            mo = 16'($urandom);
            spi_frame(mo, 16, -1, rx, extra, oe0);
            e = model_next();
            check("rnd miso", rx, {16'd0, e});
            check("rnd cfg", {16'd0, cfg_word}, {16'd0, mo});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
